// File: rtl/dcim_pkg.sv
// Shared sizing, state encoding and helpers for the DCIM host sequencer.
package dcim_pkg;

    localparam int N_ROWS = 8;
    localparam int D_W    = 24;
    localparam int X_W    = 192;
    localparam int N_W    = 51;

    // Row counter must be able to hold N_ROWS itself: that value marks a complete burst.
    localparam int RC_W = $clog2(N_ROWS + 1);
    localparam logic [RC_W-1:0] ROWS_FULL = RC_W'(N_ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_WGAP,
        S_XSETUP,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    function automatic logic [N_ROWS-1:0] onehot_row(input logic [RC_W-1:0] idx);
        return N_ROWS'(1) << idx;
    endfunction

endpackage

// File: rtl/dcim_edge_det.sv
// Registers the macro done flag and flags its rising edge; the edge is suppressed while reset is high.
module dcim_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q & ~rst;

endmodule

// File: rtl/dcim_host_seq.sv
// Host-side sequencer driving the DCIM macro weight-write and compute ports from valid/ready streams.
// Optional watchdog on the compute wait is enabled by defining DCIM_TIMEOUT_EN.
module dcim_host_seq
   import dcim_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic [D_W-1:0]    w_data,
   input  logic              x_valid,
   output logic              x_ready,
   input  logic [X_W-1:0]    x_data,
   input  logic              x_inwidth,
   input  logic              x_wwidth,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [N_W-1:0]    res_data,
   output logic              busy,
   output logic [N_ROWS-1:0] WA,
   output logic [D_W-1:0]    D,
   output logic              acm_en,
   output logic              cima,
   output logic              inwidth,
   output logic              wwidth,
   output logic              start,
   output logic [X_W-1:0]    xin0,
   input  logic [N_W-1:0]    nout,
   input  logic              st
`ifdef DCIM_TIMEOUT_EN
   ,
   output logic              timeout_err
`endif
);

   state_t          state;
   logic [RC_W-1:0] row_cnt;
   logic            done;
   logic            w_fire;
   logic            x_fire;
   logic            res_fire;

`ifdef DCIM_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt;
`endif

   dcim_edge_det u_st_edge (
      .clk  (clk),
      .rst  (rst),
      .sig  (st),
      .rise (done)
   );

   // A pending partial burst keeps the sequencer in WLOAD, which blocks compute requests.
   assign w_ready  = ~rst & ((state == S_IDLE) | ((state == S_WLOAD) & (row_cnt < ROWS_FULL)));
   assign x_ready  = ~rst & (state == S_IDLE) & ~w_valid;
   assign w_fire   = w_valid & w_ready;
   assign x_fire   = x_valid & x_ready;
   assign res_fire = res_valid & res_ready;
   assign cima     = 1'b0;

   // Main sequencer: weight burst loading, compute launch, done capture and response hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         row_cnt   <= '0;
         WA        <= '0;
         D         <= '0;
         acm_en    <= 1'b0;
         inwidth   <= 1'b0;
         wwidth    <= 1'b0;
         start     <= 1'b0;
         xin0      <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         busy      <= 1'b0;
`ifdef DCIM_TIMEOUT_EN
         to_cnt      <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         WA    <= '0;
         start <= 1'b0;
         case (state)
            S_IDLE, S_WLOAD: begin
               if (w_fire) begin
                  WA      <= onehot_row(row_cnt);
                  D       <= w_data;
                  row_cnt <= row_cnt + 1'b1;
                  acm_en  <= 1'b1;
                  busy    <= 1'b1;
                  state   <= S_WLOAD;
               end else if (x_fire) begin
                  xin0    <= x_data;
                  inwidth <= x_inwidth;
                  wwidth  <= x_wwidth;
                  acm_en  <= 1'b1;
                  busy    <= 1'b1;
                  state   <= S_XSETUP;
               end else if ((state == S_WLOAD) && (row_cnt == ROWS_FULL)) begin
                  D       <= '0;
                  row_cnt <= '0;
                  state   <= S_WGAP;
               end
            end
            S_WGAP: begin
               acm_en <= 1'b0;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
            S_XSETUP: begin
               start <= 1'b1;
               state <= S_START;
            end
            S_START: begin
`ifdef DCIM_TIMEOUT_EN
               to_cnt <= '0;
`endif
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (done) begin
                  res_data  <= nout;
                  res_valid <= 1'b1;
                  acm_en    <= 1'b0;
                  state     <= S_RESP;
`ifdef DCIM_TIMEOUT_EN
               end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  res_data    <= '1;
                  res_valid   <= 1'b1;
                  timeout_err <= 1'b1;
                  acm_en      <= 1'b0;
                  state       <= S_RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
`endif
               end
            end
            S_RESP: begin
               if (res_fire) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
`ifdef DCIM_TIMEOUT_EN
                  timeout_err <= 1'b0;
`endif
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dcim_host_seq.md
Name: dcim_host_seq

Overview:
- Host-side initiator for the DCIM macro `top`. It drives the macro's weight-write port (WA/D/acm_en/cima) and compute port (inwidth/wwidth/xin0/start), and collects nout when st asserts.
- Upstream it exposes three valid/ready streams: weight words, activation vectors, and results.
- It replaces bench-style stimulus with synthesizable sequencing, so the macro can sit behind a system bus or DMA.

Parameters:
- N_ROWS, 8, weight rows per bank; WA is one-hot over N_ROWS bits.
- D_W, 24, weight word width.
- X_W, 192, activation vector width.
- N_W, 51, macro result width.
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with DCIM_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- w_valid  in  1  weight word valid
- w_ready  out  1  weight word accepted when w_valid&w_ready
- w_data  in  D_W  weight word; consecutive words map to rows 0..N_ROWS-1
- x_valid  in  1  compute request valid
- x_ready  out  1  compute request accepted when x_valid&x_ready
- x_data  in  X_W  activation vector
- x_inwidth  in  1  input-width mode for this request
- x_wwidth  in  1  weight-width mode for this request
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when res_valid&res_ready
- res_data  out  N_W  captured nout
- busy  out  1  high in any state other than IDLE
- WA  out  N_ROWS  one-hot row write enable to macro
- D  out  D_W  weight data to macro
- acm_en  out  1  macro access enable
- cima  out  1  macro mode, tied 0 (write/compute via acm_en)
- inwidth  out  1  to macro
- wwidth  out  1  to macro
- start  out  1  one-cycle compute start pulse
- xin0  out  X_W  activation vector to macro
- nout  in  N_W  macro result
- st  in  1  macro done

Behaviour:
- Reset (any cycle, including mid-burst or mid-compute):
  - all outputs 0; row_cnt=0; state=IDLE; any partial weight burst is discarded.
  - st/nout are ignored in the cycle rst is high.
- States: IDLE, WLOAD, WGAP, XSETUP, START, WAIT, RESP.
- Weight words are accepted only in IDLE/WLOAD while row_cnt<N_ROWS.
  - Accepting a word registers WA=1<<row_cnt, D=w_data and acm_en=1 on the next cycle, for exactly 1 cycle per word; row_cnt then increments.
  - Between words, when w_valid is low, WA=0 and D holds its value.
- After row N_ROWS-1 is accepted: state goes to WGAP for 1 cycle with WA=0, D=0, then returns to IDLE with row_cnt=0.
- IDLE with row_cnt≠0 is WLOAD. A partial burst stays pending and x_ready stays 0 until the burst completes.
- x_ready=1 only in IDLE with row_cnt==0.
  - If w_valid and x_valid are both high in IDLE, the weight word wins and x_ready=0 that cycle.
- x accept:
  - latch xin0, inwidth and wwidth; these are held stable until the next x accept.
  - XSETUP for 1 cycle, then START with start=1 for exactly 1 cycle, then WAIT.
- WAIT:
  - a done event is st==1 with st_q==0, where st_q is st registered. Sampling begins the cycle after start.
  - If st was already high at START, completion requires it to fall first.
  - On done: res_data<=nout captured in that same cycle, res_valid<=1, go to RESP.
- RESP:
  - res_valid and res_data are held until res_ready; the handshake cycle clears res_valid and returns to IDLE.
  - No new w/x is accepted while in RESP.
- acm_en=1 in WLOAD/WGAP/XSETUP/START/WAIT, 0 in IDLE/RESP. cima is always 0.
- Latency: x accept to start = 2 cycles; done to res_valid = 1 cycle.

Optional Feature:
- Macro: DCIM_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - At TIMEOUT_CYC it moves to RESP with res_data=all-ones and asserts output port timeout_err for the response cycle(s).
  - timeout_err clears on the res handshake.
- Without the macro: no counter and no timeout_err port; WAIT waits indefinitely.

Decomposition:
- Package dcim_pkg holds:
  - N_ROWS, D_W, X_W, N_W;
  - state enum typedef;
  - function onehot_row(idx).
- One sub-module, dcim_edge_det (st registration and rising-edge detect), is natural. All else stays flat.

Test Plan:
- Weight burst: 8 words 0x000001..0x000008 with w_valid continuous -> WA=01,02,04,…,80 on consecutive cycles with matching D; then 1 cycle of WA=00, D=0; then busy=0.
- Compute: x_data=all-F, x_inwidth=0, x_wwidth=0; model asserts st 12 cycles after start with nout=0x1_2345_6789_ABCD -> start high exactly 2 cycles after x accept; res_valid 1 cycle after st rises; res_data matches.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid/res_data stable; x_ready=0 throughout; 1 cycle after handshake, x_ready=1.
- Contention: w_valid and x_valid both high in IDLE -> weight accepted first; x accepted only after the 8-word burst plus gap.
- Reset mid-op: rst during WAIT at row_cnt=3 of a later burst -> all outputs 0 the next cycle; a late st pulse produces no res_valid.
- DCIM_TIMEOUT_EN with TIMEOUT_CYC=16, st never rises -> res_valid with res_data all-ones and timeout_err=1 after 16 WAIT cycles.
